// File: rtl/rx_sbinit.sv
`default_nettype none
// ============================================================================
// Module   : rx_sbinit
// Brief    : Responder half of the SBINIT link-training step. Waits for the
//            partner's Out_of_Reset, then its done_req, answers with
//            done_resp over the shared sideband, and reports completion or
//            timeout to the LTSM.
// Revision : 1.0 - initial release
// ============================================================================
module rx_sbinit #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 8000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_SBINIT_en,
    input  logic                    i_rx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_sb_busy,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_tx_valid,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
    output logic                    o_valid_rx,
    output logic                    o_SBINIT_end_rx,
    output logic                    o_timeout
);

    localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_TMO_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [SB_MSG_WIDTH-1:0] C_MSG_NONE      = SB_MSG_WIDTH'(0);
    localparam logic [SB_MSG_WIDTH-1:0] C_MSG_DONE_REQ  = SB_MSG_WIDTH'(1);
    localparam logic [SB_MSG_WIDTH-1:0] C_MSG_DONE_RESP = SB_MSG_WIDTH'(2);
    localparam logic [SB_MSG_WIDTH-1:0] C_MSG_OOR       = SB_MSG_WIDTH'(3);

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_WAIT_OOR      = 3'd1,
        S_WAIT_DONE_REQ = 3'd2,
        S_WAIT_SB_FREE  = 3'd3,
        S_SEND_RESP     = 3'd4,
        S_SBINIT_END    = 3'd5,
        S_TIMEOUT       = 3'd6
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [C_CNT_W-1:0]        r_cnt;
    logic                      w_tmo_hit;
    logic                      w_counting;
    logic [SB_MSG_WIDTH-1:0]   r_msg;
    logic                      r_valid;
    logic                      r_end;
    logic                      r_timeout;

    assign w_tmo_hit  = (r_cnt == C_TMO_LAST);
    assign w_counting = (r_state == S_WAIT_OOR)      ||
                        (r_state == S_WAIT_DONE_REQ) ||
                        (r_state == S_WAIT_SB_FREE)  ||
                        (r_state == S_SEND_RESP);

    // Next-state decode: the handshake step wins over the timeout, and a
    // dropped enable overrides everything.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_SBINIT_en) w_next = S_WAIT_OOR;
            end
            S_WAIT_OOR: begin
                if (i_rx_msg_valid && (i_decoded_SB_msg == C_MSG_OOR))
                    w_next = S_WAIT_DONE_REQ;
                else if (w_tmo_hit)
                    w_next = S_TIMEOUT;
            end
            S_WAIT_DONE_REQ: begin
                if (i_rx_msg_valid && (i_decoded_SB_msg == C_MSG_DONE_REQ))
                    w_next = S_WAIT_SB_FREE;
                else if (w_tmo_hit)
                    w_next = S_TIMEOUT;
            end
            S_WAIT_SB_FREE: begin
                // The transmit controller keeps priority on the shared SB.
                if (!i_sb_busy && !i_tx_valid)
                    w_next = S_SEND_RESP;
                else if (w_tmo_hit)
                    w_next = S_TIMEOUT;
            end
            S_SEND_RESP: begin
                if (i_falling_edge_busy)
                    w_next = S_SBINIT_END;
                else if (w_tmo_hit)
                    w_next = S_TIMEOUT;
            end
            S_SBINIT_END: w_next = S_SBINIT_END;
            S_TIMEOUT:    w_next = S_TIMEOUT;
            default:      w_next = S_IDLE;
        endcase
        if (!i_SBINIT_en) w_next = S_IDLE;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Saturating timeout counter: cleared on the way to IDLE, frozen once done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (w_next == S_IDLE)
            r_cnt <= '0;
        else if (w_counting && (r_cnt != C_CNT_MAX))
            r_cnt <= r_cnt + C_CNT_W'(1);
    end

    // Registered outputs decoded from the upcoming state, so each output
    // appears in the first cycle of the state that owns it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_msg     <= C_MSG_NONE;
            r_valid   <= 1'b0;
            r_end     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid   <= (w_next == S_SEND_RESP);
            r_end     <= (w_next == S_SBINIT_END);
            r_timeout <= (w_next == S_TIMEOUT);
            // Message code lingers after valid drops until IDLE clears it.
            if (w_next == S_IDLE)
                r_msg <= C_MSG_NONE;
            else if (w_next == S_SEND_RESP)
                r_msg <= C_MSG_DONE_RESP;
        end
    end

    assign o_encoded_SB_msg_rx = r_msg;
    assign o_valid_rx          = r_valid;
    assign o_SBINIT_end_rx     = r_end;
    assign o_timeout           = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rx_sbinit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_sbinit
// Brief    : Directed self-checking bench for rx_sbinit with a progress-flag
//            reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_sbinit;

    localparam int W   = 4;
    localparam int TMO = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         rxv = 1'b0;
    logic [W-1:0] msg = '0;
    logic         busy = 1'b0;
    logic         feb = 1'b0;
    logic         txv = 1'b0;
    logic [W-1:0] o_msg;
    logic         o_valid;
    logic         o_end;
    logic         o_tmo;

    int n_checks = 0;
    int n_errors = 0;

    rx_sbinit #(.SB_MSG_WIDTH(W), .TIMEOUT_CYCLES(TMO)) u_dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_SBINIT_en         (en),
        .i_rx_msg_valid      (rxv),
        .i_decoded_SB_msg    (msg),
        .i_sb_busy           (busy),
        .i_falling_edge_busy (feb),
        .i_tx_valid          (txv),
        .o_encoded_SB_msg_rx (o_msg),
        .o_valid_rx          (o_valid),
        .o_SBINIT_end_rx     (o_end),
        .o_timeout           (o_tmo)
    );

    always #5 clk = ~clk;

    // Reference model: handshake progress as flags plus elapsed cycles.
    bit m_act, m_oor, m_req, m_gnt, m_done, m_tmo, m_ev;
    int m_el;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !en) begin
            m_act = 0; m_oor = 0; m_req = 0; m_gnt = 0;
            m_done = 0; m_tmo = 0; m_el = 0;
        end else if (!m_act) begin
            m_act = 1;
        end else if (!m_done && !m_tmo) begin
            m_ev = 0;
            if (!m_oor) begin
                m_ev = rxv && (msg == 3);
                if (m_ev) m_oor = 1;
            end else if (!m_req) begin
                m_ev = rxv && (msg == 1);
                if (m_ev) m_req = 1;
            end else if (!m_gnt) begin
                m_ev = !busy && !txv;
                if (m_ev) m_gnt = 1;
            end else begin
                m_ev = feb;
                if (m_ev) m_done = 1;
            end
            if (!m_ev && (m_el == TMO - 1)) m_tmo = 1;
            if (m_el < TMO) m_el++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (o_valid !== (m_gnt && !m_done && !m_tmo)) begin
                n_errors++;
                $display("FAIL model_valid t=%0t: got %0b expected %0b", $time, o_valid, m_gnt && !m_done && !m_tmo);
            end
            n_checks++;
            if (o_end !== m_done) begin
                n_errors++;
                $display("FAIL model_end t=%0t: got %0b expected %0b", $time, o_end, m_done);
            end
            n_checks++;
            if (o_tmo !== m_tmo) begin
                n_errors++;
                $display("FAIL model_timeout t=%0t: got %0b expected %0b", $time, o_tmo, m_tmo);
            end
            n_checks++;
            if (o_msg !== (m_gnt ? W'(2) : W'(0))) begin
                n_errors++;
                $display("FAIL model_msg t=%0t: got %0d expected %0d", $time, o_msg, m_gnt ? 2 : 0);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [W-1:0] code);
        rxv = 1'b1;
        msg = code;
        step(1);
        rxv = 1'b0;
        msg = '0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, int'(o_valid), 0);
        chk({nm, "_msg"},   int'(o_msg),   0);
        chk({nm, "_end"},   int'(o_end),   0);
        chk({nm, "_tmo"},   int'(o_tmo),   0);
    endtask

    initial begin
        int codes[8];
        codes = '{1, 0, 2, 3, 0, 2, 3, 1};

        // Reset state
        step(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        step(2);
        chk_all_zero("idle");

        // 1. Nominal handshake
        en = 1'b1;
        step(5);
        strobe(3);
        step(4);
        strobe(1);
        chk("nom_c11_valid", int'(o_valid), 0);
        step(1);
        chk("nom_c12_valid", int'(o_valid), 1);
        chk("nom_c12_msg",   int'(o_msg),   2);
        step(8);
        feb = 1'b1;
        step(1);
        feb = 1'b0;
        chk("nom_c21_valid", int'(o_valid), 0);
        chk("nom_c21_end",   int'(o_end),   1);
        chk("nom_c21_msg",   int'(o_msg),   2);
        step(3);
        chk("nom_end_held",  int'(o_end),   1);
        en = 1'b0;
        step(1);
        chk_all_zero("nom_disable");

        // 2. Arbitration with the transmit controller, then 5. abort
        txv = 1'b1;
        en  = 1'b1;
        step(1);
        strobe(3);
        strobe(1);
        for (int i = 0; i < 6; i++) begin
            chk("arb_txv_valid", int'(o_valid), 0);
            step(1);
        end
        txv  = 1'b0;
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("arb_busy_valid", int'(o_valid), 0);
            step(1);
        end
        busy = 1'b0;
        chk("arb_free_valid", int'(o_valid), 0);
        step(1);
        chk("arb_rise_valid", int'(o_valid), 1);
        chk("arb_rise_msg",   int'(o_msg),   2);
        en = 1'b0;
        step(1);
        chk_all_zero("abort");
        en = 1'b1;
        step(1);
        strobe(3);
        strobe(1);
        step(1);
        chk("reen_valid", int'(o_valid), 1);
        feb = 1'b1;
        step(1);
        feb = 1'b0;
        chk("reen_end", int'(o_end), 1);
        en = 1'b0;
        step(1);

        // 3. Message ordering and wrong codes
        en = 1'b1;
        step(1);
        for (int i = 0; i < 8; i++) strobe(W'(codes[i]));
        chk("ord_c9_valid", int'(o_valid), 0);
        step(1);
        chk("ord_c10_valid", int'(o_valid), 1);
        feb = 1'b1;
        step(1);
        feb = 1'b0;
        chk("ord_end", int'(o_end), 1);
        en = 1'b0;
        step(1);

        // Completion and timeout in the same cycle: completion wins
        en = 1'b1;
        step(1);
        strobe(3);
        strobe(1);
        step(21);
        feb = 1'b1;
        step(1);
        feb = 1'b0;
        chk("race_end", int'(o_end), 1);
        chk("race_tmo", int'(o_tmo), 0);
        en = 1'b0;
        step(1);

        // 4. Timeout with no partner messages
        en = 1'b1;
        step(TMO);
        chk("tmo_before", int'(o_tmo), 0);
        step(1);
        chk("tmo_at",       int'(o_tmo),   1);
        chk("tmo_valid",    int'(o_valid), 0);
        step(4);
        chk("tmo_sticky",   int'(o_tmo),   1);
        en = 1'b0;
        step(1);
        chk("tmo_cleared",  int'(o_tmo),   0);

        // 6. Asynchronous reset in SEND_RESP
        en = 1'b1;
        step(1);
        strobe(3);
        strobe(1);
        step(1);
        chk("ar_pre_valid", int'(o_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step(2);
        rst_n = 1'b1;
        en    = 1'b0;
        step(2);
        chk_all_zero("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
